sn_popcount_seq: RTL and testbench
==================================

// Module: sn_popcount_seq
// PURPOSE
//  Multi-cycle popcount controller around one sorter7_1bit. Accepts a DATA_W-bit word,
//  slices it into 7-bit chunks, feeds one chunk per cycle through the sorter,
//  decodes the thermometer output and accumulates the count. Returns the total popcount
//  over a valid/ready handshake. Trades latency for area against a flat SN-based counter.
// PARAMETERS
//  DATA_W   28                       input word width, >= 1
//  NCHUNK   (DATA_W+6)/7             number of 7-bit chunks (derived, localparam)
//  CNT_W    $clog2(DATA_W+1)         width of out_count (derived, localparam)
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       in_data valid
//  in_ready   out  1       block can accept a word
//  in_data    in   DATA_W  word to count
//  out_valid  out  1       out_count valid
//  out_ready  in   1       consumer accepts out_count
//  out_count  out  CNT_W   number of 1 bits in the accepted word
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, in_ready=1, out_valid=0, out_count=0, acc=0, idx=0.
//    Reset mid-operation discards the word in flight; no output is produced for it.
//  - FSM: IDLE -> RUN on (in_valid & in_ready): latch in_data zero-padded to NCHUNK*7,
//    clear acc, idx=0. RUN: sorter input = chunk[idx] (bits 7*idx+6 : 7*idx),
//    acc += chunk_count, idx++. On idx==NCHUNK-1, go to DONE. DONE: out_valid=1,
//    out_count=acc held stable until (out_valid & out_ready), then -> IDLE.
//  - in_ready=1 only in IDLE; no overlap of words. A word presented in the same cycle
//    out_ready completes DONE is not accepted (in_ready still 0); it is taken the next cycle.
//  - Chunk decode: sorter places ones at the top, so c ones give Out[6:7-c]=1,
//    Out[6-c:0]=0. chunk_count = 7 - (index of lowest set Out bit); 0 if Out==0.
//    Non-thermometer Out is not expected. Decode uses thermometer position, not popcount.
//  - Latency: out_valid rises NCHUNK+1 cycles after the accept edge (without the pipe option).
//  - Arithmetic: acc is CNT_W bits; max total = DATA_W, no overflow possible. Padding bits
//    are 0 and contribute nothing.
//  - DATA_W<=7: NCHUNK=1; RUN lasts one cycle.
//  - out_valid stays high with out_ready low indefinitely. out_count is stable while held.
// CONFIGURATION
//  SN_POPCOUNT_PIPE_EN defined: a register sits between the sorter output and the decoder.
//    RUN lasts NCHUNK+1 cycles (one drain cycle after the last chunk).
//    Latency = NCHUNK+2 cycles accept->out_valid. Results are otherwise identical.
//  Undefined: sorter output is decoded combinationally in the same cycle. Latency NCHUNK+1.
// STRUCTURE
//  - Shared package sn_pc_pkg: state enum {IDLE, RUN, DONE}, localparam SORT_N=7, and
//    function therm7_to_bin(input [6:0]) returning [2:0].
//    Other SN counters reuse the same package.
//  - One sub-module: sorter7_1bit instantiated once, unmodified.
//  - Chunk mux, idx counter, accumulator and FSM stay in this module.
// TESTING
//  1 DATA_W=28. Accept 28'h0000000 -> out_count=0, out_valid 5 cycles after accept (6 with PIPE_EN).
//  2 Accept 28'hFFFFFFF -> out_count=28. Accept 28'h000007F -> 7. Accept 28'h8000001 -> 2.
//  3 Backpressure: out_ready=0 for 10 cycles -> out_valid and out_count held, in_ready=0.
//    Release -> one transfer, then IDLE.
//  4 Assert rst at RUN idx=2 with in_data=28'hFFFFFFF -> next cycle in_ready=1, out_valid=0.
//    Next word 28'h0000003 -> out_count=2. No stale accumulation.
//  5 DATA_W=10: in_data=10'h3FF -> 10 (padding ignored). DATA_W=5: in_data=5'h15 -> 3, NCHUNK=1.
//  6 Random: 1000 back-to-back words, random out_ready -> out_count == $countones(in_data)
//    for each word, in order, none dropped or duplicated.

Source files
------------

// File: rtl/sn_pc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sn_pc_pkg
//  Description : Shared definitions for the sorting-network popcount family.
//                Holds the controller state encoding, the sorter width and
//                the thermometer-to-binary decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package sn_pc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SORT_N = 7;

    // The sorter pushes ones to the top. With c ones, the lowest set bit sits
    // at index 7-c. The count is therefore read from the position of that bit,
    // not from a popcount of the vector.
    function automatic logic [2:0] therm7_to_bin(input logic [6:0] therm);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (therm[i]) begin
                cnt = 3'(7 - i);
            end
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sorter7_1bit.sv
`default_nettype none
// ============================================================================
//  Module      : sorter7_1bit
//  Description : 7-input, 1-bit odd-even transposition sorting network.
//                Each compare-exchange is an AND (low lane) and an OR (high
//                lane), so all ones end up at the top of out_bits.
//  Revision    : 1.0  initial release
// ============================================================================
module sorter7_1bit
    import sn_pc_pkg::*;
(
    input  logic [SORT_N-1:0] in_bits,
    output logic [SORT_N-1:0] out_bits
);

    // Lane vectors between stages; N stages of transposition sort N lanes.
    logic [SORT_N:0][SORT_N-1:0] w_stage;

    assign w_stage[0] = in_bits;

    for (genvar s = 0; s < SORT_N; s++) begin : g_stage
        for (genvar i = 0; i < SORT_N; i++) begin : g_lane
            if ((i < SORT_N - 1) && ((i % 2) == (s % 2))) begin : g_low
                assign w_stage[s+1][i] = w_stage[s][i] & w_stage[s][i+1];
            end else if ((i >= 1) && (((i - 1) % 2) == (s % 2))) begin : g_high
                assign w_stage[s+1][i] = w_stage[s][i] | w_stage[s][i-1];
            end else begin : g_pass
                assign w_stage[s+1][i] = w_stage[s][i];
            end
        end
    end

    assign out_bits = w_stage[SORT_N];

endmodule
`default_nettype wire

// File: rtl/sn_popcount_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sn_popcount_seq
//  Description : Multi-cycle popcount controller. Feeds one 7-bit chunk per
//                cycle through a single sorter7_1bit, decodes its thermometer
//                output and accumulates the total, returned over valid/ready.
//  Option      : SN_POPCOUNT_PIPE_EN -- register between sorter and decoder,
//                adds one drain cycle to RUN.
//  Revision    : 1.0  initial release
// ============================================================================
module sn_popcount_seq
    import sn_pc_pkg::*;
#(
    parameter  int DATA_W = 28,
    localparam int NCHUNK = (DATA_W + 6) / 7,
    localparam int CNT_W  = $clog2(DATA_W + 1)
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count
);

    localparam int PAD_W = NCHUNK * SORT_N;
    localparam int IDX_W = $clog2(NCHUNK + 1);

`ifdef SN_POPCOUNT_PIPE_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PAD_W-1:0]    r_data;
    logic [IDX_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_acc;
    logic [SORT_N-1:0]   w_sorted;
    logic [SORT_N-1:0]   w_dec_in;
    logic [2:0]          w_chunk_cnt;
    logic                w_add_en;
    logic                w_accept;
    logic                w_last;

    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_idx == LAST_IDX);
    assign out_count = r_acc;

    // The latched word shifts right one chunk per RUN cycle, so chunk[idx]
    // is always the low 7 bits; zero fill keeps padding and drain chunks empty.
    sorter7_1bit u_sorter (
        .in_bits  (r_data[SORT_N-1:0]),
        .out_bits (w_sorted)
    );

`ifdef SN_POPCOUNT_PIPE_EN
    logic [SORT_N-1:0] r_sorted;

    // Sorter output register; its content lags the chunk index by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sorted <= '0;
        end else begin
            r_sorted <= w_sorted;
        end
    end

    assign w_dec_in = r_sorted;
    // At idx 0 the register still holds data from before this word.
    assign w_add_en = (r_state == RUN) && (r_idx != '0);
`else
    assign w_dec_in = w_sorted;
    assign w_add_en = (r_state == RUN);
`endif

    assign w_chunk_cnt = therm7_to_bin(w_dec_in);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; ready only in IDLE, so words never overlap.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Word latch, chunk index and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_idx  <= '0;
            r_acc  <= '0;
        end else if (w_accept) begin
            r_data <= PAD_W'(in_data);
            r_idx  <= '0;
            r_acc  <= '0;
        end else if (r_state == RUN) begin
            r_data <= r_data >> SORT_N;
            r_idx  <= r_idx + IDX_W'(1);
            if (w_add_en) begin
                r_acc <= r_acc + CNT_W'(w_chunk_cnt);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sn_popcount_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sn_popcount_seq
//  Description : Self-checking bench for sn_popcount_seq at DATA_W=28, with
//                small DATA_W=10 and DATA_W=5 instances for the padding and
//                single-chunk cases. Expected counts come from $countones.
//  Option      : honours SN_POPCOUNT_PIPE_EN for the expected latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sn_popcount_seq;

`ifdef SN_POPCOUNT_PIPE_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT28 = 4 + 1 + EXTRA;
    localparam int LAT10 = 2 + 1 + EXTRA;
    localparam int LAT5  = 1 + 1 + EXTRA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [27:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_count;

    logic        v10 = 1'b0, r10, ov10, or10 = 1'b1;
    logic [9:0]  d10 = '0;
    logic [3:0]  c10;
    logic        v5 = 1'b0, r5, ov5, or5 = 1'b1;
    logic [4:0]  d5 = '0;
    logic [2:0]  c5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sn_popcount_seq #(.DATA_W(28)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count)
    );

    sn_popcount_seq #(.DATA_W(10)) dut10 (
        .clk(clk), .rst(rst), .in_valid(v10), .in_ready(r10),
        .in_data(d10), .out_valid(ov10), .out_ready(or10),
        .out_count(c10)
    );

    sn_popcount_seq #(.DATA_W(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(v5), .in_ready(r5),
        .in_data(d5), .out_valid(ov5), .out_ready(or5),
        .out_count(c5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One word through the 28-bit instance: latency, count, optional hold, release.
    task automatic run_word(input logic [27:0] d, input int hold);
        int lat;
        logic [4:0] held;
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        check("ready_before_word", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            check("busy_in_ready", in_ready, 0);
            tick();
            lat++;
        end
        check("latency", lat, LAT28);
        check("count", out_count, $countones(d));
        held = out_count;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_count", out_count, held);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("released_valid", out_valid, 0);
        check("released_in_ready", in_ready, 1);
    endtask

    initial begin
        int q[$];
        int sent;
        int done;
        int cyc;
        int n;
        int exp_cnt;
        bit holding;
        logic [4:0] held;

        repeat (3) tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", out_count, 0);

        // Directed words, including a 10-cycle backpressure hold.
        run_word(28'h0000000, 0);
        run_word(28'hFFFFFFF, 10);
        run_word(28'h000007F, 0);
        run_word(28'h8000001, 0);

        // Reset while RUN is at chunk 2 of an all-ones word.
        in_valid = 1'b1;
        in_data  = 28'hFFFFFFF;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        run_word(28'h0000003, 0);

        // A word offered while DONE completes is only taken a cycle later.
        in_valid = 1'b1;
        in_data  = 28'h0000F0F;
        tick();
        in_data = 28'h0000001;
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("done_no_overlap_ready", in_ready, 1);
        check("done_no_overlap_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check("taken_next_cycle", out_count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Narrow widths: zero padding and the single-chunk case.
        v10 = 1'b1; d10 = 10'h3FF;
        v5  = 1'b1; d5  = 5'h15;
        tick();
        v10 = 1'b0; v5 = 1'b0;
        n = 1;
        while (!ov5 && n < 20) begin tick(); n++; end
        check("w5_latency", n, LAT5);
        check("w5_count", c5, 3);
        while (!ov10 && n < 20) begin tick(); n++; end
        check("w10_latency", n, LAT10);
        check("w10_count", c10, 10);
        tick();
        check("w10_idle", r10, 1);
        check("w5_idle", r5, 1);

        // Random traffic against a queue of expected counts.
        sent = 0; done = 0; cyc = 0; holding = 0; held = '0;
        while (done < 1000 && cyc < 40000) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_data   = 28'($urandom);
            out_ready = $urandom_range(0, 1) != 0;
            check("rnd_in_ready", in_ready, (q.size() == 0) ? 1 : 0);
            if (holding) begin
                check("rnd_hold_valid", out_valid, 1);
                check("rnd_hold_count", out_count, held);
            end
            if (in_valid && in_ready) begin
                q.push_back($countones(in_data));
                sent++;
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("rnd_spurious_out", out_valid, 0);
                end else if (out_ready) begin
                    exp_cnt = q.pop_front();
                    check("rnd_count", out_count, exp_cnt);
                    done++;
                end
            end
            holding = out_valid && !out_ready;
            held    = out_count;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rnd_words_done", done, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
